mesi_isc_cpu_port: RTL and testbench

MESI_ISC_CPU_PORT -- requirements
Module: mesi_isc_cpu_port

---
 rtl/mesi_isc_cpu_port_if.sv | 49 ++++
 rtl/mesi_isc_cpu_port.sv | 201 ++++++++++++++++++++
 tb/tb_mesi_isc_cpu_port.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mesi_isc_cpu_port_if.sv
// Purpose: signal bundle between a CPU port of the MESI intersection controller,
//          its CPU/cache side and the controller's main and coherence buses.
// Modports:
//   master - CPU/cache and controller side: drives requests, mbus ack, cbus
//            commands and snoop completion; observes everything the port drives.
//   slave  - the CPU port block itself.
// Signals:
//   req_valid_i/req_type_i/req_addr_i/req_ready_o - CPU request handshake
//   done_o                                        - request completion pulse
//   mbus_cmd_o/mbus_addr_o/mbus_ack_i             - main bus
//   cbus_cmd_i/cbus_addr_i/cbus_ack_o             - coherence bus
//   snoop_valid_o/snoop_wr_o/snoop_addr_o/snoop_ready_i - snoop to the cache
//   err_o                                         - sticky protocol error
interface mesi_isc_cpu_port_if #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned MBUS_CMD_WIDTH = 3,
    parameter int unsigned CBUS_CMD_WIDTH = 3
);
    logic                      req_valid_i;
    logic [1:0]                req_type_i;
    logic [ADDR_WIDTH-1:0]     req_addr_i;
    logic                      req_ready_o;
    logic                      done_o;
    logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_o;
    logic [ADDR_WIDTH-1:0]     mbus_addr_o;
    logic                      mbus_ack_i;
    logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i;
    logic [ADDR_WIDTH-1:0]     cbus_addr_i;
    logic                      cbus_ack_o;
    logic                      snoop_valid_o;
    logic                      snoop_wr_o;
    logic [ADDR_WIDTH-1:0]     snoop_addr_o;
    logic                      snoop_ready_i;
    logic                      err_o;

    modport master (
        output req_valid_i, req_type_i, req_addr_i, mbus_ack_i,
               cbus_cmd_i, cbus_addr_i, snoop_ready_i,
        input  req_ready_o, done_o, mbus_cmd_o, mbus_addr_o, cbus_ack_o,
               snoop_valid_o, snoop_wr_o, snoop_addr_o, err_o
    );

    modport slave (
        input  req_valid_i, req_type_i, req_addr_i, mbus_ack_i,
               cbus_cmd_i, cbus_addr_i, snoop_ready_i,
        output req_ready_o, done_o, mbus_cmd_o, mbus_addr_o, cbus_ack_o,
               snoop_valid_o, snoop_wr_o, snoop_addr_o, err_o
    );
endinterface

// File: rtl/mesi_isc_cpu_port.sv
// Purpose: one CPU port of a MESI intersection controller. A request FSM issues
//          the CPU request on the main bus and waits for the matching enable on
//          the coherence bus; a snoop FSM forwards coherence snoops to the cache
//          and acknowledges every coherence command exactly once.
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-high reset
//   bus - mesi_isc_cpu_port_if.slave (request, mbus, cbus, snoop, err)
// Build option:
//   MESI_ISC_CPU_PORT_TIMEOUT_EN - adds a 16-bit WAIT_EN watchdog that gives up
//   after TIMEOUT_CYCLES cycles, flags err_o and returns to IDLE.
module mesi_isc_cpu_port #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned MBUS_CMD_WIDTH = 3,
    parameter int unsigned CBUS_CMD_WIDTH = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                clk,
    input logic                rst,
    mesi_isc_cpu_port_if.slave bus
);

    localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_NOP      = MBUS_CMD_WIDTH'(0);
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_WR_SNOOP = CBUS_CMD_WIDTH'(1);
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_RD_SNOOP = CBUS_CMD_WIDTH'(2);
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_EN_WR    = CBUS_CMD_WIDTH'(3);
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_EN_RD    = CBUS_CMD_WIDTH'(4);

    // Reject a watchdog limit the 16-bit counter cannot represent.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
        $error("mesi_isc_cpu_port: TIMEOUT_CYCLES must be 1..65535");
    end

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_EN,
        ACK_EN,
        DONE
    } req_state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CACHE,
        S_ACK,
        S_GUARD
    } snp_state_t;

    req_state_t req_state, req_next;
    snp_state_t snp_state, snp_next;

    logic [1:0]                type_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic                      accept;
    logic                      is_snoop;
    logic                      is_en;
    logic                      en_match;
    logic                      en_take;
    logic                      en_err;
    logic                      snoop_latch;
    logic                      timeout;
    logic                      err_set;
    logic [1:0]                cmd_type;
    logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_d;

`ifdef MESI_ISC_CPU_PORT_TIMEOUT_EN
    localparam int unsigned WAIT_CNT_W = 16;
    logic [WAIT_CNT_W-1:0] wait_cnt;

    // Cycles spent in WAIT_EN; cleared whenever WAIT_EN is left.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (req_state == WAIT_EN && req_next == WAIT_EN) begin
            wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end
`endif

    // Coherence command decode. Type bit 0 set means a read (RD, RD_BROAD).
    always_comb begin
        accept   = bus.req_valid_i && bus.req_ready_o;
        is_snoop = (bus.cbus_cmd_i == CBUS_WR_SNOOP) || (bus.cbus_cmd_i == CBUS_RD_SNOOP);
        is_en    = (bus.cbus_cmd_i == CBUS_EN_WR) || (bus.cbus_cmd_i == CBUS_EN_RD);
        en_match = (req_state == WAIT_EN) && (bus.cbus_addr_i == addr_q) &&
                   (((bus.cbus_cmd_i == CBUS_EN_WR) && !type_q[0]) ||
                    ((bus.cbus_cmd_i == CBUS_EN_RD) &&  type_q[0]));
        // The cbus is only decoded outside the ack and guard cycles.
        en_take  = ((snp_state == S_IDLE) || (snp_state == S_CACHE)) && en_match;
    end

    // Snoop FSM: also owns the single-cycle ack and guard for EN commands.
    always_comb begin
        snp_next    = snp_state;
        en_err      = 1'b0;
        snoop_latch = 1'b0;
        case (snp_state)
            S_IDLE: begin
                if (is_en) begin
                    snp_next = S_ACK;
                    en_err   = !en_match;
                end else if (is_snoop) begin
                    snp_next    = S_CACHE;
                    snoop_latch = 1'b1;
                end
            end
            S_CACHE: begin
                // An EN during an open snoop is a protocol error; the EN wins.
                if (is_en) begin
                    snp_next = S_ACK;
                    en_err   = 1'b1;
                end else if (bus.snoop_ready_i) begin
                    snp_next = S_ACK;
                end
            end
            S_ACK:   snp_next = S_GUARD;
            S_GUARD: snp_next = S_IDLE;
            default: snp_next = S_IDLE;
        endcase
    end

    // Request FSM and next main-bus command.
    always_comb begin
        req_next = req_state;
        timeout  = 1'b0;
        case (req_state)
            IDLE:    if (accept) req_next = REQ;
            REQ:     if (bus.mbus_ack_i) req_next = WAIT_EN;
            WAIT_EN: begin
                if (en_take) begin
                    req_next = ACK_EN;
                end
`ifdef MESI_ISC_CPU_PORT_TIMEOUT_EN
                else if (wait_cnt == WAIT_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    req_next = IDLE;
                    timeout  = 1'b1;
                end
`endif
            end
            ACK_EN:  req_next = DONE;
            DONE:    req_next = IDLE;
            default: req_next = IDLE;
        endcase

        cmd_type   = accept ? bus.req_type_i : type_q;
        mbus_cmd_d = MBUS_NOP;
        if (req_next == REQ) begin
            mbus_cmd_d = MBUS_CMD_WIDTH'(cmd_type) + MBUS_CMD_WIDTH'(1);
        end
        err_set = en_err || timeout;
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_state <= IDLE;
            snp_state <= S_IDLE;
        end else begin
            req_state <= req_next;
            snp_state <= snp_next;
        end
    end

    // Latched request and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            type_q            <= '0;
            addr_q            <= '0;
            bus.req_ready_o   <= 1'b0;
            bus.done_o        <= 1'b0;
            bus.mbus_cmd_o    <= MBUS_NOP;
            bus.mbus_addr_o   <= '0;
            bus.cbus_ack_o    <= 1'b0;
            bus.snoop_valid_o <= 1'b0;
            bus.snoop_wr_o    <= 1'b0;
            bus.snoop_addr_o  <= '0;
            bus.err_o         <= 1'b0;
        end else begin
            if (accept) begin
                type_q          <= bus.req_type_i;
                addr_q          <= bus.req_addr_i;
                bus.mbus_addr_o <= bus.req_addr_i;
            end
            if (snoop_latch) begin
                bus.snoop_wr_o   <= (bus.cbus_cmd_i == CBUS_WR_SNOOP);
                bus.snoop_addr_o <= bus.cbus_addr_i;
            end
            bus.req_ready_o   <= (req_next == IDLE);
            bus.done_o        <= (req_next == DONE);
            bus.mbus_cmd_o    <= mbus_cmd_d;
            bus.cbus_ack_o    <= (snp_next == S_ACK) || (req_next == ACK_EN);
            bus.snoop_valid_o <= (snp_next == S_CACHE);
            if (err_set) begin
                bus.err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mesi_isc_cpu_port.sv
// Purpose: directed self-checking bench for mesi_isc_cpu_port. Inputs change and
//          outputs are sampled on the falling clock edge.
module tb_mesi_isc_cpu_port;

    localparam int unsigned AW = 32;
`ifdef MESI_ISC_CPU_PORT_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 8;
`else
    localparam int unsigned TB_TIMEOUT = 255;
`endif

    localparam logic [2:0] C_NOP      = 3'd0;
    localparam logic [2:0] C_WR_SNOOP = 3'd1;
    localparam logic [2:0] C_RD_SNOOP = 3'd2;
    localparam logic [2:0] C_EN_WR    = 3'd3;
    localparam logic [2:0] C_EN_RD    = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;
    int n_ack   = 0;
    int n_done  = 0;

    mesi_isc_cpu_port_if #(
        .ADDR_WIDTH(AW), .MBUS_CMD_WIDTH(3), .CBUS_CMD_WIDTH(3)
    ) bus ();

    mesi_isc_cpu_port #(
        .ADDR_WIDTH(AW), .MBUS_CMD_WIDTH(3), .CBUS_CMD_WIDTH(3),
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Hard stop if something hangs.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge, tallying ack and done pulses.
    task automatic step();
        @(negedge clk);
        if (bus.cbus_ack_o) n_ack++;
        if (bus.done_o) n_done++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drive_idle();
        bus.req_valid_i   = 1'b0;
        bus.req_type_i    = 2'd0;
        bus.req_addr_i    = '0;
        bus.mbus_ack_i    = 1'b0;
        bus.cbus_cmd_i    = C_NOP;
        bus.cbus_addr_i   = '0;
        bus.snoop_ready_i = 1'b0;
    endtask

    task automatic apply_reset();
        drive_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic start_req(input logic [1:0] t, input logic [31:0] a);
        bus.req_valid_i = 1'b1;
        bus.req_type_i  = t;
        bus.req_addr_i  = a;
        step();
        bus.req_valid_i = 1'b0;
    endtask

    task automatic mbus_ack_pulse();
        bus.mbus_ack_i = 1'b1;
        step();
        bus.mbus_ack_i = 1'b0;
    endtask

    // Controller side: hold a cbus command until it is acknowledged.
    task automatic cbus_send(input logic [2:0] cmd, input logic [31:0] a, input string tag);
        bit seen = 1'b0;
        bus.cbus_cmd_i  = cmd;
        bus.cbus_addr_i = a;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (bus.cbus_ack_o) seen = 1'b1;
        end
        bus.cbus_cmd_i = C_NOP;
        check_eq(tag, 32'(seen), 1);
    endtask

    initial begin
        drive_idle();
        rst = 1'b1;
        step();
        step();
        check_eq("rst_req_ready",   32'(bus.req_ready_o),   0);
        check_eq("rst_mbus_cmd",    32'(bus.mbus_cmd_o),    0);
        check_eq("rst_mbus_addr",   32'(bus.mbus_addr_o),   0);
        check_eq("rst_cbus_ack",    32'(bus.cbus_ack_o),    0);
        check_eq("rst_snoop_valid", 32'(bus.snoop_valid_o), 0);
        check_eq("rst_snoop_wr",    32'(bus.snoop_wr_o),    0);
        check_eq("rst_snoop_addr",  32'(bus.snoop_addr_o),  0);
        check_eq("rst_done",        32'(bus.done_o),        0);
        check_eq("rst_err",         32'(bus.err_o),         0);
        rst = 1'b0;
        step();
        check_eq("ready_after_rst", 32'(bus.req_ready_o), 1);

        // mbus ack while idle has no effect.
        bus.mbus_ack_i = 1'b1;
        step();
        bus.mbus_ack_i = 1'b0;
        check_eq("idle_mack_ready", 32'(bus.req_ready_o), 1);
        check_eq("idle_mack_cmd",   32'(bus.mbus_cmd_o),  0);

        // RD_BROAD 0x100, mbus ack after 2 cycles, EN_RD 3 cycles later.
        n_ack = 0; n_done = 0;
        start_req(2'd3, 32'h100);
        check_eq("rdb_cmd_c1",   32'(bus.mbus_cmd_o),  4);
        check_eq("rdb_addr",     bus.mbus_addr_o,      32'h100);
        check_eq("rdb_ready_lo", 32'(bus.req_ready_o), 0);
        step();
        check_eq("rdb_cmd_c2",   32'(bus.mbus_cmd_o),  4);
        mbus_ack_pulse();
        check_eq("rdb_cmd_nop",  32'(bus.mbus_cmd_o),  0);
        run(3);
        check_eq("rdb_no_early_done", 32'(n_done), 0);
        cbus_send(C_EN_RD, 32'h100, "rdb_en_ack");
        run(3);
        check_eq("rdb_acks",  32'(n_ack),  1);
        check_eq("rdb_dones", 32'(n_done), 1);
        check_eq("rdb_err",   32'(bus.err_o), 0);
        check_eq("rdb_ready", 32'(bus.req_ready_o), 1);

        // WR 0x80 with a WR_SNOOP 0x40 serviced while in WAIT_EN.
        n_ack = 0; n_done = 0;
        start_req(2'd0, 32'h80);
        check_eq("wr_cmd", 32'(bus.mbus_cmd_o), 1);
        mbus_ack_pulse();
        bus.cbus_cmd_i  = C_WR_SNOOP;
        bus.cbus_addr_i = 32'h40;
        step();
        check_eq("snp_valid",  32'(bus.snoop_valid_o), 1);
        check_eq("snp_wr",     32'(bus.snoop_wr_o),    1);
        check_eq("snp_addr",   bus.snoop_addr_o,       32'h40);
        run(2);
        check_eq("snp_valid_held", 32'(bus.snoop_valid_o), 1);
        check_eq("snp_no_ack_yet", 32'(n_ack), 0);
        bus.snoop_ready_i = 1'b1;
        step();
        check_eq("snp_ack", 32'(bus.cbus_ack_o), 1);
        bus.cbus_cmd_i    = C_NOP;
        bus.snoop_ready_i = 1'b0;
        step();
        check_eq("snp_valid_drop", 32'(bus.snoop_valid_o), 0);
        check_eq("snp_one_ack",    32'(n_ack), 1);
        check_eq("snp_req_wait",   32'(bus.req_ready_o), 0);
        cbus_send(C_EN_WR, 32'h80, "wr_en_ack");
        run(3);
        check_eq("wr_acks",  32'(n_ack),  2);
        check_eq("wr_dones", 32'(n_done), 1);
        check_eq("wr_err",   32'(bus.err_o), 0);

        // RD_SNOOP held for 5 cycles with the cache ready: one ack in that
        // window. The guard lets the still-held command start a fresh snoop
        // in the fifth cycle, whose ack falls after the command is dropped.
        n_ack = 0;
        bus.cbus_cmd_i    = C_RD_SNOOP;
        bus.cbus_addr_i   = 32'h44;
        bus.snoop_ready_i = 1'b1;
        step();
        check_eq("hold_valid", 32'(bus.snoop_valid_o), 1);
        check_eq("hold_wr",    32'(bus.snoop_wr_o),    0);
        check_eq("hold_addr",  bus.snoop_addr_o,       32'h44);
        run(4);
        check_eq("hold_one_ack", 32'(n_ack), 1);
        bus.cbus_cmd_i = C_NOP;
        run(6);
        bus.snoop_ready_i = 1'b0;
        check_eq("hold_valid_end", 32'(bus.snoop_valid_o), 0);
        check_eq("hold_err",       32'(bus.err_o), 0);

        // EN_WR to the wrong address while waiting on RD 0x100.
        n_ack = 0; n_done = 0;
        start_req(2'd1, 32'h100);
        check_eq("rd_cmd", 32'(bus.mbus_cmd_o), 2);
        mbus_ack_pulse();
        cbus_send(C_EN_WR, 32'h200, "bad_en_ack");
        run(3);
        check_eq("bad_en_err",   32'(bus.err_o), 1);
        check_eq("bad_en_acks",  32'(n_ack), 1);
        check_eq("bad_en_wait",  32'(bus.req_ready_o), 0);
        check_eq("bad_en_nodone", 32'(n_done), 0);
        cbus_send(C_EN_RD, 32'h100, "good_en_ack");
        run(3);
        check_eq("good_en_done", 32'(n_done), 1);
        check_eq("err_sticky",   32'(bus.err_o), 1);

        // Reset in the middle of REQ.
        start_req(2'd2, 32'h500);
        check_eq("wrb_cmd",  32'(bus.mbus_cmd_o), 3);
        check_eq("wrb_addr", bus.mbus_addr_o, 32'h500);
        rst = 1'b1;
        #1;
        check_eq("midrst_cmd",   32'(bus.mbus_cmd_o),  0);
        check_eq("midrst_addr",  32'(bus.mbus_addr_o), 0);
        check_eq("midrst_ready", 32'(bus.req_ready_o), 0);
        check_eq("midrst_err",   32'(bus.err_o),       0);
        step();
        rst = 1'b0;
        step();
        check_eq("midrst_ready_after", 32'(bus.req_ready_o), 1);
        check_eq("midrst_cmd_after",   32'(bus.mbus_cmd_o),  0);

        // EN while idle: error, still acked once.
        n_ack = 0; n_done = 0;
        cbus_send(C_EN_RD, 32'h100, "idle_en_ack");
        run(2);
        check_eq("idle_en_err",   32'(bus.err_o), 1);
        check_eq("idle_en_acks",  32'(n_ack), 1);
        check_eq("idle_en_nodone", 32'(n_done), 0);
        check_eq("idle_en_ready", 32'(bus.req_ready_o), 1);

        apply_reset();
        n_done = 0;
        start_req(2'd1, 32'h600);
        mbus_ack_pulse();
`ifdef MESI_ISC_CPU_PORT_TIMEOUT_EN
        // Now in the first WAIT_EN cycle; give up after the eighth.
        run(7);
        check_eq("to_err_before",   32'(bus.err_o), 0);
        check_eq("to_ready_before", 32'(bus.req_ready_o), 0);
        step();
        check_eq("to_err",    32'(bus.err_o), 1);
        check_eq("to_ready",  32'(bus.req_ready_o), 1);
        check_eq("to_nodone", 32'(n_done), 0);
`else
        // Without the watchdog, WAIT_EN waits indefinitely.
        run(300);
        check_eq("wait_ready", 32'(bus.req_ready_o), 0);
        check_eq("wait_err",   32'(bus.err_o), 0);
        check_eq("wait_nodone", 32'(n_done), 0);
        cbus_send(C_EN_RD, 32'h600, "wait_en_ack");
        run(3);
        check_eq("wait_done", 32'(n_done), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
